ml605_pcie_reset_seq: RTL and testbench
=======================================

# ml605_pcie_reset_seq

Parametrised, synthesizable reset and PERST# sequencer for one or more PCIe endpoint channels. It generalises the fixed-length system-reset and PERST# generation used around the ml605_pcie system. It adds per-channel link-training supervision with timeout, bounded retry, link-drop recovery and software restart. It sits between the board reset and each PCIe endpoint, and drives each endpoint's PERST# from the same clock domain.

## Interface
- NUM_EP, 1: number of independent endpoint channels (≥1)
- SYS_RST_CYCLES, 16: cycles `sys_rst_out` stays high after RESET is released (≥1)
- PERST_CYCLES, 160: cycles PERST# is held low per assertion (≥1)
- LINK_TIMEOUT, 1000: cycles allowed in training before a retry (≥2)
- STABLE_CYCLES, 4: consecutive `link_up` cycles required to declare the link up (≥1)
- MAX_RETRY, 3: number of timeout retries before a channel fails (0..255)
- CNT_W, 16: counter width; must hold max(SYS_RST_CYCLES, PERST_CYCLES, LINK_TIMEOUT)
- CLK  in  1  sole clock; every input is synchronous to it
- RESET  in  1  synchronous, active-high reset
- link_up  in  NUM_EP  per-channel link-up status from each endpoint
- restart  in  NUM_EP  per-channel single-cycle restart request
- sys_rst_out  out  1  active-high system reset to downstream logic
- perst_n  out  NUM_EP  per-channel PERST#, active low
- link_ok  out  NUM_EP  channel is in the UP state
- fail  out  NUM_EP  channel has exhausted its retries
- all_up  out  1  AND of all `link_ok` bits, registered
- retry_cnt  out  NUM_EP*8  per-channel retry count; channel i is in bits [8i+7:8i]

## Operation
- The top-level FSM has two states:
  - S_RST: `sys_rst_out`=1; the counter counts up to SYS_RST_CYCLES.
  - S_RUN: `sys_rst_out`=0. S_RUN is terminal until RESET.
- Each channel has its own FSM. All channels sit in CH_IDLE while the top FSM is in S_RST.
- CH_IDLE: `perst_n`=0. Moves to CH_PERST in the cycle the top FSM enters S_RUN.
- CH_PERST: `perst_n`=0. Counts PERST_CYCLES, then moves to CH_TRAIN.
- CH_TRAIN: `perst_n`=1.
  - Run counter and stability counter both start at 0.
  - The stability counter clears on any cycle where `link_up`=0.
  - Stability counter reaches STABLE_CYCLES → CH_UP.
  - Run counter reaches LINK_TIMEOUT with retries < MAX_RETRY → retries+1, go to CH_PERST.
  - Run counter reaches LINK_TIMEOUT with retries = MAX_RETRY → CH_FAIL.
- CH_UP: `perst_n`=1, `link_ok`=1. `link_up`=0 for one cycle (link drop) → clear retries, go to CH_PERST.
- CH_FAIL: `perst_n`=0, `fail`=1. Sticky; only `restart` or RESET leaves it.
- `restart[i]` in any state except CH_IDLE → CH_PERST, with retries cleared and `fail` cleared. It is ignored in CH_IDLE.
- Priority within one cycle: restart > stability reached > timeout > link drop.
- Retry counter saturates at 255. MAX_RETRY=0 means the first timeout goes directly to CH_FAIL.

## Timing
- All outputs are registered. Reset values: `sys_rst_out`=1, `perst_n`=0, `link_ok`=0, `fail`=0, `all_up`=0, `retry_cnt`=0.
- RESET asserted mid-operation returns every FSM and counter to its reset value on the next edge. No partial state survives.
- Call the first edge with RESET=0 edge 0. `sys_rst_out` falls at edge SYS_RST_CYCLES.
- `perst_n` rises PERST_CYCLES edges after CH_PERST is entered.
- Let edge k be the first edge at which `link_up` is sampled high. If it stays high, `link_ok` rises at edge k+STABLE_CYCLES-1. `all_up` follows one edge later.
- Timeout: `perst_n` falls on the edge after the LINK_TIMEOUT-th cycle in CH_TRAIN.
- Link drop or restart: `perst_n` and `link_ok` fall on the first edge that samples the event.

## Structure
- Package `ml605_pcie_reset_seq_pkg` holds:
  - the channel state enum (CH_IDLE, CH_PERST, CH_TRAIN, CH_UP, CH_FAIL)
  - the top state enum
  - the retry width constant (8)
  - a clog2 helper
- Sub-module `ml605_pcie_reset_seq_ch` implements one channel FSM with its counters. The top level instantiates it NUM_EP times in a generate loop and owns S_RST/S_RUN and `all_up`.

## Test plan
Defaults unless stated; NUM_EP=2.
- Reset release, `link_up`=1 from edge 0 → `sys_rst_out` falls at edge 16; `perst_n` rises at edge 177; `link_ok` rises at edge 180; `all_up`=1 at edge 181.
- Channel 0 `link_up` held 0 → three retries, each with `perst_n` low 160 cycles. After the 4th timeout, `fail[0]`=1, `perst_n[0]`=0 and `retry_cnt[0]`=3. Channel 1 is unaffected.
- `link_up` glitches 1,1,1,0,1,1,1,1 in CH_TRAIN → `link_ok` rises only after the final four 1s.
- Channel in CH_UP, `link_up` drops 1 cycle → `perst_n` goes low next edge and `retry_cnt` clears. With `link_up`=1 again, the link recovers after 160+4 cycles.
- `restart[1]` pulsed while in CH_FAIL, and separately on the same cycle as stability completion → CH_PERST in both cases, with `fail[1]`=0.
- RESET asserted for 1 cycle while in CH_TRAIN → all outputs return to reset values on the next edge, and the full sequence restarts.

Source files
------------

// File: rtl/ml605_pcie_reset_seq_pkg.sv
// Shared types and constants for the PCIe reset / PERST# sequencer.
package ml605_pcie_reset_seq_pkg;

  localparam int RETRY_W = 8;

  typedef enum logic [2:0] {
    CH_IDLE,
    CH_PERST,
    CH_TRAIN,
    CH_UP,
    CH_FAIL
  } ch_state_e;

  typedef enum logic {
    S_RST,
    S_RUN
  } top_state_e;

  // Bits needed to encode values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ml605_pcie_reset_seq_ch.sv
// One endpoint channel: PERST# pulse, link-training supervision, retry and recovery.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// CH_IDLE  | system still in reset, PERST# low, waiting for run
// CH_PERST | PERST# held low for PERST_CYCLES
// CH_TRAIN | PERST# released, waiting for a stable link or the timeout
// CH_UP    | link stable, link_ok high; any link_up drop re-pulses PERST#
// CH_FAIL  | retries exhausted, PERST# low; left only by restart or RESET
module ml605_pcie_reset_seq_ch
  import ml605_pcie_reset_seq_pkg::*;
#(
  parameter int PERST_CYCLES  = 160,
  parameter int LINK_TIMEOUT  = 1000,
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               run,
  input  logic               link_up,
  input  logic               restart,
  output logic               perst_n,
  output logic               link_ok,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int STAB_W = clog2(STABLE_CYCLES + 1);

  // Down-counter reload values: terminal count is zero.
  localparam logic [CNT_W-1:0]   PERST_LOAD   = CNT_W'(PERST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LOAD = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST    = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_SAT    = '1;

  ch_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [STAB_W-1:0]  stab;

  // Channel FSM with its timer, stability counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= CH_IDLE;
      cnt       <= '0;
      stab      <= '0;
      perst_n   <= 1'b0;
      link_ok   <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else if (restart && (state != CH_IDLE)) begin
      state     <= CH_PERST;
      cnt       <= PERST_LOAD;
      stab      <= '0;
      perst_n   <= 1'b0;
      link_ok   <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      case (state)
        CH_IDLE: begin
          if (run) begin
            state <= CH_PERST;
            cnt   <= PERST_LOAD;
          end
        end
        CH_PERST: begin
          if (cnt == '0) begin
            state   <= CH_TRAIN;
            cnt     <= TIMEOUT_LOAD;
            // The edge that releases PERST# already samples link_up and counts it.
            stab    <= link_up ? STAB_W'(1) : '0;
            perst_n <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CH_TRAIN: begin
          if (link_up && (stab >= STAB_LAST)) begin
            state   <= CH_UP;
            link_ok <= 1'b1;
          end else if (cnt == '0) begin
            perst_n <= 1'b0;
            stab    <= '0;
            if (retry_cnt < RETRY_MAX) begin
              state     <= CH_PERST;
              cnt       <= PERST_LOAD;
              retry_cnt <= (retry_cnt == RETRY_SAT) ? retry_cnt : retry_cnt + RETRY_W'(1);
            end else begin
              state <= CH_FAIL;
              fail  <= 1'b1;
            end
          end else begin
            cnt  <= cnt - CNT_W'(1);
            stab <= link_up ? stab + STAB_W'(1) : '0;
          end
        end
        CH_UP: begin
          if (!link_up) begin
            state     <= CH_PERST;
            cnt       <= PERST_LOAD;
            stab      <= '0;
            perst_n   <= 1'b0;
            link_ok   <= 1'b0;
            retry_cnt <= '0;
          end
        end
        CH_FAIL: begin
          perst_n <= 1'b0;
          fail    <= 1'b1;
        end
        default: begin
          state   <= CH_IDLE;
          perst_n <= 1'b0;
          link_ok <= 1'b0;
          fail    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ml605_pcie_reset_seq.sv
// Board-level reset and PERST# sequencer for NUM_EP PCIe endpoint channels.
//
// state | meaning
// ------+------------------------------------------------------------
// S_RST | sys_rst_out high, counting SYS_RST_CYCLES after RESET drops
// S_RUN | sys_rst_out low, channels released; terminal until RESET
module ml605_pcie_reset_seq
  import ml605_pcie_reset_seq_pkg::*;
#(
  parameter int NUM_EP         = 1,
  parameter int SYS_RST_CYCLES = 16,
  parameter int PERST_CYCLES   = 160,
  parameter int LINK_TIMEOUT   = 1000,
  parameter int STABLE_CYCLES  = 4,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_EP-1:0]         link_up,
  input  logic [NUM_EP-1:0]         restart,
  output logic                      sys_rst_out,
  output logic [NUM_EP-1:0]         perst_n,
  output logic [NUM_EP-1:0]         link_ok,
  output logic [NUM_EP-1:0]         fail,
  output logic                      all_up,
  output logic [NUM_EP*RETRY_W-1:0] retry_cnt
);

  localparam logic [CNT_W-1:0] SYS_LOAD = CNT_W'(SYS_RST_CYCLES);

  top_state_e       top_state;
  logic [CNT_W-1:0] sys_cnt;
  logic             run;

  assign run = (top_state == S_RUN);

  // System reset stretcher: holds sys_rst_out for SYS_RST_CYCLES edges.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      top_state   <= S_RST;
      sys_cnt     <= SYS_LOAD;
      sys_rst_out <= 1'b1;
    end else begin
      case (top_state)
        S_RST: begin
          if (sys_cnt == '0) begin
            top_state   <= S_RUN;
            sys_rst_out <= 1'b0;
          end else begin
            sys_cnt <= sys_cnt - CNT_W'(1);
          end
        end
        S_RUN: begin
          sys_rst_out <= 1'b0;
        end
      endcase
    end
  end

  // Registered summary of every channel being up.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      all_up <= 1'b0;
    end else begin
      all_up <= &link_ok;
    end
  end

  for (genvar i = 0; i < NUM_EP; i++) begin : g_ch
    ml605_pcie_reset_seq_ch #(
      .PERST_CYCLES  (PERST_CYCLES),
      .LINK_TIMEOUT  (LINK_TIMEOUT),
      .STABLE_CYCLES (STABLE_CYCLES),
      .MAX_RETRY     (MAX_RETRY),
      .CNT_W         (CNT_W)
    ) u_ch (
      .CLK       (CLK),
      .RESET     (RESET),
      .run       (run),
      .link_up   (link_up[i]),
      .restart   (restart[i]),
      .perst_n   (perst_n[i]),
      .link_ok   (link_ok[i]),
      .fail      (fail[i]),
      .retry_cnt (retry_cnt[RETRY_W*i +: RETRY_W])
    );
  end

endmodule

// File: tb/tb_ml605_pcie_reset_seq.sv
// Directed bench for ml605_pcie_reset_seq with two channels and default timing.
module tb_ml605_pcie_reset_seq;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [1:0]  link_up = 2'b00;
  logic [1:0]  restart = 2'b00;
  logic        sys_rst_out;
  logic [1:0]  perst_n;
  logic [1:0]  link_ok;
  logic [1:0]  fail;
  logic        all_up;
  logic [15:0] retry_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  ml605_pcie_reset_seq #(.NUM_EP(2)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .link_up     (link_up),
    .restart     (restart),
    .sys_rst_out (sys_rst_out),
    .perst_n     (perst_n),
    .link_ok     (link_ok),
    .fail        (fail),
    .all_up      (all_up),
    .retry_cnt   (retry_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_sys_rst"}, 32'(sys_rst_out), 32'h1);
    check_val({tag, "_perst_n"}, 32'(perst_n),     32'h0);
    check_val({tag, "_link_ok"}, 32'(link_ok),     32'h0);
    check_val({tag, "_fail"},    32'(fail),        32'h0);
    check_val({tag, "_all_up"},  32'(all_up),      32'h0);
    check_val({tag, "_retry"},   32'(retry_cnt),   32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset with both links already up.
    RESET   = 1'b1;
    link_up = 2'b11;
    restart = 2'b00;
    repeat (3) step();
    check_reset_vals("por");
    RESET  = 1'b0;
    edge_n = -1;

    // Phase A: nominal bring-up.
    run_to(15);  check_val("sys_rst_hold", 32'(sys_rst_out), 32'h1);
    run_to(16);  check_val("sys_rst_fall", 32'(sys_rst_out), 32'h0);
                 check_val("perst_at16",   32'(perst_n),     32'h0);
    run_to(176); check_val("perst_176",    32'(perst_n),     32'h0);
    run_to(177); check_val("perst_rise",   32'(perst_n),     32'h3);
                 check_val("link_ok_177",  32'(link_ok),     32'h0);
    run_to(179); check_val("link_ok_179",  32'(link_ok),     32'h0);
    run_to(180); check_val("link_ok_rise", 32'(link_ok),     32'h3);
                 check_val("all_up_180",   32'(all_up),      32'h0);
    run_to(181); check_val("all_up_rise",  32'(all_up),      32'h1);

    // One-cycle link drop on channel 1.
    run_to(200); link_up = 2'b01;
    run_to(201); link_up = 2'b11;
                 check_val("drop_perst",   32'(perst_n),     32'h1);
                 check_val("drop_link_ok", 32'(link_ok),     32'h1);
                 check_val("drop_retry",   32'(retry_cnt),   32'h0);
    run_to(202); check_val("drop_all_up",  32'(all_up),      32'h0);
    run_to(360); check_val("rec_perst_lo", 32'(perst_n),     32'h1);
    run_to(361); check_val("rec_perst_hi", 32'(perst_n),     32'h3);
    run_to(363); check_val("rec_lok_363",  32'(link_ok),     32'h1);
    run_to(364); check_val("rec_lok_364",  32'(link_ok),     32'h3);

    // Restart channel 1 from UP, then again on its stability-completion edge.
    run_to(399); restart = 2'b10;
    run_to(400); restart = 2'b00;
                 check_val("rst_up_perst", 32'(perst_n),     32'h1);
                 check_val("rst_up_lok",   32'(link_ok),     32'h1);
    run_to(562); check_val("rst_stb_pre",  32'(perst_n),     32'h3);
                 check_val("rst_stb_lok0", 32'(link_ok),     32'h1);
                 restart = 2'b10;
    run_to(563); restart = 2'b00;
                 check_val("rst_stb_lok",  32'(link_ok),     32'h1);
                 check_val("rst_stb_perst",32'(perst_n),     32'h1);
                 check_val("rst_stb_fail", 32'(fail),        32'h0);
    run_to(725); check_val("rst_stb_725",  32'(link_ok),     32'h1);
    run_to(726); check_val("rst_stb_726",  32'(link_ok),     32'h3);
    run_to(727); check_val("rst_stb_all",  32'(all_up),      32'h1);

    // Phase B: restart both; channel 0 never trains, channel 1 does.
    run_to(799); restart = 2'b11; link_up = 2'b10;
    run_to(800); restart = 2'b00;
                 check_val("b_perst_800",  32'(perst_n),     32'h0);
                 check_val("b_lok_800",    32'(link_ok),     32'h0);
    run_to(963); check_val("b_lok_963",    32'(link_ok),     32'h2);
                 check_val("b_perst_963",  32'(perst_n),     32'h3);
    run_to(1959);check_val("b_perst_1959", 32'(perst_n),     32'h3);
                 check_val("b_retry_1959", 32'(retry_cnt),   32'h0);
    run_to(1960);check_val("b_perst_1960", 32'(perst_n),     32'h2);
                 check_val("b_retry_1960", 32'(retry_cnt),   32'h1);
    run_to(2149);check_val("b_pre_perst",  32'(perst_n),     32'h3);
                 check_val("b_pre_lok",    32'(link_ok),     32'h2);
                 check_val("b_pre_retry",  32'(retry_cnt),   32'h1);
                 check_val("b_pre_sys",    32'(sys_rst_out), 32'h0);
                 RESET = 1'b1;
    run_to(2150);check_reset_vals("mid_reset");
                 RESET  = 1'b0;
                 edge_n = -1;

    // Phase C: full sequence again; channel 0 exhausts its retries.
    run_to(15);  check_val("c_sys_hold",   32'(sys_rst_out), 32'h1);
    run_to(16);  check_val("c_sys_fall",   32'(sys_rst_out), 32'h0);
    run_to(177); check_val("c_perst_177",  32'(perst_n),     32'h3);
    run_to(180); check_val("c_lok_180",    32'(link_ok),     32'h2);
    run_to(1176);check_val("c_perst_1176", 32'(perst_n),     32'h3);
                 check_val("c_retry_1176", 32'(retry_cnt),   32'h0);
    run_to(1177);check_val("c_perst_1177", 32'(perst_n),     32'h2);
                 check_val("c_retry_1177", 32'(retry_cnt),   32'h1);
    run_to(1336);check_val("c_perst_1336", 32'(perst_n),     32'h2);
    run_to(1337);check_val("c_perst_1337", 32'(perst_n),     32'h3);
    run_to(2337);check_val("c_retry_2337", 32'(retry_cnt),   32'h2);
                 check_val("c_perst_2337", 32'(perst_n),     32'h2);
    run_to(3497);check_val("c_retry_3497", 32'(retry_cnt),   32'h3);
    run_to(4656);check_val("c_fail_4656",  32'(fail),        32'h0);
                 check_val("c_perst_4656", 32'(perst_n),     32'h3);
    run_to(4657);check_val("c_fail_4657",  32'(fail),        32'h1);
                 check_val("c_perst_4657", 32'(perst_n),     32'h2);
                 check_val("c_retry_4657", 32'(retry_cnt),   32'h3);
                 check_val("c_lok_4657",   32'(link_ok),     32'h2);
                 check_val("c_all_4657",   32'(all_up),      32'h0);

    // Drive channel 1 into CH_FAIL, then restart it from there.
    run_to(4699);link_up = 2'b00; restart = 2'b10;
    run_to(4700);restart = 2'b00;
                 check_val("f1_perst_4700",32'(perst_n),     32'h0);
                 check_val("f1_lok_4700",  32'(link_ok),     32'h0);
    run_to(9339);check_val("f1_fail_9339", 32'(fail),        32'h1);
                 check_val("f1_retry_9339",32'(retry_cnt),   32'h0303);
                 check_val("f1_perst_9339",32'(perst_n),     32'h2);
    run_to(9340);check_val("f1_fail_9340", 32'(fail),        32'h3);
                 check_val("f1_perst_9340",32'(perst_n),     32'h0);
    run_to(9399);restart = 2'b10; link_up = 2'b10;
    run_to(9400);restart = 2'b00;
                 check_val("f1_rst_fail",  32'(fail),        32'h1);
                 check_val("f1_rst_retry", 32'(retry_cnt),   32'h0003);
                 check_val("f1_rst_perst", 32'(perst_n),     32'h0);
    run_to(9559);check_val("f1_perst_9559",32'(perst_n),     32'h0);
    run_to(9560);check_val("f1_perst_9560",32'(perst_n),     32'h2);
    run_to(9562);check_val("f1_lok_9562",  32'(link_ok),     32'h0);
    run_to(9563);check_val("f1_lok_9563",  32'(link_ok),     32'h2);
                 check_val("f1_fail0_keep",32'(fail),        32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
